// File: rtl/adc_align_fsm_pkg.sv
// Shared types and default constants for the ADC frame-alignment trainer.
package adc_align_fsm_pkg;

    localparam int unsigned ADC_DATA_W        = 16;
    localparam logic [ADC_DATA_W-1:0] ADC_TRAIN_PATTERN = 16'hA5C3;
    localparam int unsigned ADC_MATCH_COUNT   = 16;
    localparam int unsigned ADC_SETTLE_CYCLES = 4;
    localparam int unsigned ADC_MAX_SLIPS     = 8;
    localparam int unsigned ADC_SLIP_W        = $clog2(ADC_MAX_SLIPS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED,
        ST_FAIL
    } align_state_t;

endpackage

// File: rtl/adc_align_fsm_if.sv
// Control/data bundle between the alignment trainer and its deserializer-side user.
interface adc_align_fsm_if
    import adc_align_fsm_pkg::*;
#(
    parameter int unsigned DATA_W = ADC_DATA_W,
    parameter int unsigned SLIP_W = ADC_SLIP_W
);
    logic              start;
    logic [DATA_W-1:0] d_in;
    logic              bitslip;
    logic              locked;
    logic              fail;
    logic [SLIP_W-1:0] slip_count;
    logic [DATA_W-1:0] d_out;
    logic              d_valid;

    modport master (
        output start, d_in,
        input  bitslip, locked, fail, slip_count, d_out, d_valid
    );

    modport slave (
        input  start, d_in,
        output bitslip, locked, fail, slip_count, d_out, d_valid
    );
endinterface

// File: rtl/adc_align_fsm.sv
// Frame-alignment trainer: slips the 2-lane deserializer until the training
// pattern is seen MATCH_COUNT times in a row, then forwards aligned samples.
module adc_align_fsm
    import adc_align_fsm_pkg::*;
#(
    parameter int unsigned           DATA_W        = ADC_DATA_W,
    parameter logic [DATA_W-1:0]     TRAIN_PATTERN = ADC_TRAIN_PATTERN,
    parameter int unsigned           MATCH_COUNT   = ADC_MATCH_COUNT,
    parameter int unsigned           SETTLE_CYCLES = ADC_SETTLE_CYCLES,
    parameter int unsigned           MAX_SLIPS     = ADC_MAX_SLIPS
) (
    input  logic            CLKDIV,
    input  logic            RST_N,
    adc_align_fsm_if.slave  bus
);

    localparam int unsigned SLIP_W   = $clog2(MAX_SLIPS + 1);
    localparam int unsigned MATCH_W  = $clog2(MATCH_COUNT + 1);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [SLIP_W-1:0]   SLIP_MAX    = SLIP_W'(MAX_SLIPS);
    localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    align_state_t         state;
    logic [MATCH_W-1:0]   match_cnt;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [SLIP_W-1:0]    slip_count;
    logic                 bitslip;
    logic                 locked;
    logic                 fail;
    logic [DATA_W-1:0]    d_out;
    logic                 d_valid;

    // Trainer state, counters and all outputs share one register block.
    always_ff @(posedge CLKDIV or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            match_cnt  <= '0;
            settle_cnt <= '0;
            slip_count <= '0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            d_out      <= '0;
            d_valid    <= 1'b0;
        end else begin
            d_out   <= bus.d_in;
            bitslip <= 1'b0;

            if (bus.start) begin
                state      <= ST_CHECK;
                match_cnt  <= '0;
                settle_cnt <= '0;
                slip_count <= '0;
                locked     <= 1'b0;
                fail       <= 1'b0;
                d_valid    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end

                    ST_CHECK: begin
                        if (bus.d_in == TRAIN_PATTERN) begin
                            if (match_cnt == MATCH_LAST) begin
                                state     <= ST_LOCKED;
                                match_cnt <= '0;
                                locked    <= 1'b1;
                                d_valid   <= 1'b1;
                            end else begin
                                match_cnt <= match_cnt + MATCH_W'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                            if (slip_count == SLIP_MAX) begin
                                state <= ST_FAIL;
                                fail  <= 1'b1;
                            end else begin
                                // Pulse is registered here so it is high for the whole SLIP cycle.
                                state      <= ST_SLIP;
                                bitslip    <= 1'b1;
                                slip_count <= slip_count + SLIP_W'(1);
                            end
                        end
                    end

                    ST_SLIP: begin
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end

                    ST_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state      <= ST_CHECK;
                            settle_cnt <= '0;
                            match_cnt  <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + SETTLE_W'(1);
                        end
                    end

                    ST_LOCKED: begin
                        state <= ST_LOCKED;
                    end

                    ST_FAIL: begin
                        state <= ST_FAIL;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.bitslip    = bitslip;
    assign bus.locked     = locked;
    assign bus.fail       = fail;
    assign bus.slip_count = slip_count;
    assign bus.d_out      = d_out;
    assign bus.d_valid    = d_valid;

    // A slip pulse is always followed by at least the settle window.
    a_single_pulse: assert property (@(posedge CLKDIV) disable iff (!RST_N) bitslip |=> !bitslip);

endmodule

// File: tb/tb_adc_align_fsm.sv
// Self-checking bench for adc_align_fsm: directed training scenarios against a behavioural model.
module tb_adc_align_fsm;
    import adc_align_fsm_pkg::*;

    localparam logic [15:0] PAT     = 16'hA5C3;
    localparam logic [15:0] BAD     = 16'h1234;
    localparam int          MATCHES = 16;
    localparam int          SETTLE  = 4;
    localparam int          SLIPS   = 8;

    logic CLKDIV = 1'b0;
    logic RST_N  = 1'b0;

    adc_align_fsm_if bus ();

    adc_align_fsm dut (
        .CLKDIV (CLKDIV),
        .RST_N  (RST_N),
        .bus    (bus)
    );

    always #5 CLKDIV = ~CLKDIV;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] v, input int r);
        return (v << r) | (v >> (16 - r));
    endfunction

    // Stimulus source: fixed word, or a word rotated by the slips still missing.
    int          mode     = 0;
    logic [15:0] fix_val  = PAT;
    int          need_k   = 0;
    int          pulses;
    int          min_gap;
    int          last_pulse;
    int          cyc;

    initial begin
        bus.d_in = PAT;
        forever begin
            @(negedge CLKDIV);
            if (mode == 0) bus.d_in = fix_val;
            else           bus.d_in = rotl(PAT, (need_k - pulses) & 15);
        end
    end

    // Pulse monitor: count and spacing of bitslip pulses within one training run.
    always @(posedge CLKDIV or negedge RST_N) begin
        if (!RST_N) begin
            pulses     <= 0;
            min_gap    <= 999;
            last_pulse <= 0;
            cyc        <= 0;
        end else begin
            cyc <= cyc + 1;
            if (bus.start) begin
                pulses  <= 0;
                min_gap <= 999;
            end else if (bus.bitslip) begin
                pulses     <= pulses + 1;
                last_pulse <= cyc;
                if (pulses > 0 && (cyc - last_pulse) < min_gap) min_gap <= cyc - last_pulse;
            end
        end
    end

    // Behavioural model: training run with an ignore window after every slip decision.
    logic        m_active, m_locked, m_fail, m_bitslip;
    int          m_slips, m_streak, m_blind;
    logic [15:0] m_dout;

    always @(posedge CLKDIV or negedge RST_N) begin
        if (!RST_N) begin
            m_active <= 1'b0; m_locked <= 1'b0; m_fail <= 1'b0; m_bitslip <= 1'b0;
            m_slips  <= 0;    m_streak <= 0;    m_blind <= 0;   m_dout <= '0;
        end else begin
            m_dout    <= bus.d_in;
            m_bitslip <= 1'b0;
            if (bus.start) begin
                m_active <= 1'b1; m_locked <= 1'b0; m_fail <= 1'b0;
                m_slips  <= 0;    m_streak <= 0;    m_blind <= 0;
            end else if (m_active) begin
                if (m_blind > 0) begin
                    m_blind <= m_blind - 1;
                end else if (bus.d_in == PAT) begin
                    if (m_streak + 1 == MATCHES) begin
                        m_locked <= 1'b1;
                        m_active <= 1'b0;
                    end else begin
                        m_streak <= m_streak + 1;
                    end
                end else begin
                    m_streak <= 0;
                    if (m_slips == SLIPS) begin
                        m_fail   <= 1'b1;
                        m_active <= 1'b0;
                    end else begin
                        m_slips   <= m_slips + 1;
                        m_bitslip <= 1'b1;
                        m_blind   <= SETTLE + 1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge CLKDIV) begin
        chk("bitslip",    32'(bus.bitslip),    32'(m_bitslip));
        chk("locked",     32'(bus.locked),     32'(m_locked));
        chk("fail",       32'(bus.fail),       32'(m_fail));
        chk("slip_count", 32'(bus.slip_count), 32'(m_slips));
        chk("d_out",      32'(bus.d_out),      32'(m_dout));
        chk("d_valid",    32'(bus.d_valid),    32'(m_locked));
    end

    task automatic run_start();
        @(negedge CLKDIV);
        bus.start = 1'b1;
        @(posedge CLKDIV);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_lock(input int budget, output int lat);
        lat = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLKDIV);
            #1;
            lat++;
            if (bus.locked) break;
        end
    endtask

    int  lat;
    int  lat2;
    bit  seen;

    initial begin
        bus.start = 1'b0;
        repeat (3) @(negedge CLKDIV);
        chk("rst_locked",  32'(bus.locked),     32'd0);
        chk("rst_slipcnt", 32'(bus.slip_count), 32'd0);
        @(negedge CLKDIV);
        RST_N = 1'b1;

        // Reset asserted while a slip pulse is high.
        fix_val = BAD;
        run_start();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.bitslip) begin seen = 1'b1; break; end
            @(posedge CLKDIV);
            #1;
        end
        chk("t1_pulse_seen", 32'(seen), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t1_async_bitslip", 32'(bus.bitslip), 32'd0);
        chk("t1_async_locked",  32'(bus.locked),  32'd0);
        chk("t1_async_fail",    32'(bus.fail),    32'd0);
        chk("t1_async_dvalid",  32'(bus.d_valid), 32'd0);
        @(negedge CLKDIV);
        RST_N = 1'b1;
        repeat (12) @(negedge CLKDIV);
        chk("t1_idle_pulses", 32'(pulses),         32'd0);
        chk("t1_idle_slips",  32'(bus.slip_count), 32'd0);

        // Already-aligned link.
        fix_val = PAT;
        @(negedge CLKDIV);
        run_start();
        wait_lock(100, lat);
        chk("t2_latency", 32'(lat),            32'd16);
        chk("t2_slips",   32'(bus.slip_count), 32'd0);
        chk("t2_pulses",  32'(pulses),         32'd0);
        chk("t2_dvalid",  32'(bus.d_valid),    32'd1);
        chk("t2_dout",    32'(bus.d_out),      32'hA5C3);

        // Restart while locked.
        run_start();
        chk("t6_locked_drop", 32'(bus.locked),     32'd0);
        chk("t6_dvalid_drop", 32'(bus.d_valid),    32'd0);
        chk("t6_slips",       32'(bus.slip_count), 32'd0);
        wait_lock(100, lat);
        chk("t6_relock_latency", 32'(lat), 32'd16);

        // Rotating word: three slips needed.
        mode   = 1;
        need_k = 3;
        @(negedge CLKDIV);
        run_start();
        wait_lock(200, lat);
        chk("t3_locked",  32'(bus.locked),     32'd1);
        chk("t3_slips",   32'(bus.slip_count), 32'd3);
        chk("t3_pulses",  32'(pulses),         32'd3);
        chk("t3_min_gap", 32'(min_gap),        32'd6);
        chk("t3_dout",    32'(bus.d_out),      32'hA5C3);
        chk("t3_dvalid",  32'(bus.d_valid),    32'd1);
        mode = 0;

        // Match streak broken at the tenth word.
        fix_val = PAT;
        @(negedge CLKDIV);
        run_start();
        repeat (9) @(posedge CLKDIV);
        #1;
        fix_val = BAD;
        @(posedge CLKDIV);
        #1;
        fix_val = PAT;
        wait_lock(200, lat2);
        chk("t5_latency", 32'(lat2 + 10),      32'd31);
        chk("t5_slips",   32'(bus.slip_count), 32'd1);
        chk("t5_pulses",  32'(pulses),         32'd1);

        // Never matches: exhaust all slips.
        fix_val = BAD;
        @(negedge CLKDIV);
        run_start();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLKDIV);
            #1;
            if (bus.fail) begin seen = 1'b1; break; end
        end
        chk("t4_fail",   32'(seen),            32'd1);
        chk("t4_locked", 32'(bus.locked),      32'd0);
        chk("t4_slips",  32'(bus.slip_count),  32'd8);
        chk("t4_pulses", 32'(pulses),          32'd8);
        repeat (30) @(posedge CLKDIV);
        #1;
        chk("t4_no_more_pulses", 32'(pulses),   32'd8);
        chk("t4_fail_held",      32'(bus.fail), 32'd1);

        @(negedge CLKDIV);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
